// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants (hex glyph table, blank pattern, digit index width)
package seg7_pkg;
  localparam int DIG_W = $clog2(8);
  localparam logic [6:0] SEG7_BLANK = 7'h00;
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7: combinational nibble to active-high {g..a} segment lookup
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG7_HEX[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered hex scan of a 32-bit value onto a multiplexed 7-seg display; SEG7_LZ_BLANK_EN blanks leading zeros
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int NUM_DIGITS     = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           value_in,
  input  logic                  load,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0]         div;
  logic [DIG_W-1:0]      idx;
  logic [31:0]           shadow, disp, disp_nx;
  logic                  pending, tick, wrap, seen;
  logic [3:0]            nib;
  logic [6:0]            hex, seg_r;
  logic [NUM_DIGITS-1:0] an_r, lit;
  // idx names the digit that the next tick lights; the tick lighting digit 0 is the frame wrap
  assign tick    = div == DW'(SCAN_DIV - 1);
  assign wrap    = tick && idx == '0;
  assign disp_nx = !wrap ? disp : load ? value_in : pending ? shadow : disp;
  assign nib     = disp_nx[{idx, 2'b00} +: 4];
  hex_to_seg7 u_hex (.nib(nib), .seg(hex));
`ifdef SEG7_LZ_BLANK_EN
  // a digit stays lit if it or any higher digit is nonzero; digit 0 is always lit
  always_comb begin
    lit  = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen   = seen | (disp_nx[4*i +: 4] != 4'h0) | (i == 0);
      lit[i] = seen;
    end
  end
`else
  assign seen = 1'b1;
  assign lit  = '1;
`endif
  // divider, scan position, double buffer and registered pin drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an_r       <= '0;
      seg_r      <= SEG7_BLANK;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      disp       <= disp_nx;
      frame_done <= wrap;
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end
      if (wrap) pending <= 1'b0;
      if (tick) begin
        idx   <= idx == DIG_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        an_r  <= lit[idx] ? NUM_DIGITS'(1) << idx : '0;
        seg_r <= lit[idx] ? hex : SEG7_BLANK;
      end
    end
  end
  assign an  = SEG_ACTIVE_LOW ? ~an_r : an_r;
  assign seg = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign dp  = SEG_ACTIVE_LOW;
endmodule
